// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving an external magnitude comparator.
// Optional SAR_CMP_PIPE_EN inserts a SETTLE cycle before each probe for a registered comparator.
module sar_search_ctrl #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cmp_lesser,
  input  logic         cmp_greater,
  input  logic         cmp_equal,
  output logic [N-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [N-1:0] result
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(N-1);
  localparam logic [N-1:0]  MSB     = {1'b1, {(N-1){1'b0}}};

`ifdef SAR_CMP_PIPE_EN
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_PROBE, S_DONE} state_t;
  localparam state_t S_STEP = S_SETTLE;
`else
  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;
  localparam state_t S_STEP = S_PROBE;
`endif

  typedef struct packed {
    logic lesser;
    logic greater;
    logic equal;
  } cmp_flags_t;

  state_t        state;
  logic [IW-1:0] bit_idx;
  cmp_flags_t    flags;
  logic [N-1:0]  bit_mask;
  logic [N-1:0]  next_mask;
  logic [N-1:0]  guess_up;
  logic [N-1:0]  guess_down;
  logic          last_bit;

  assign flags = '{lesser: cmp_lesser, greater: cmp_greater, equal: cmp_equal};

  // Pure bit set/clear: next_mask is zero at bit 0, so guess_down then just clears bit 0.
  assign bit_mask   = N'(1) << bit_idx;
  assign next_mask  = bit_mask >> 1;
  assign guess_up   = guess | next_mask;
  assign guess_down = (guess & ~bit_mask) | next_mask;
  assign last_bit   = (bit_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      guess   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bit_idx <= TOP_IDX;
            guess   <= MSB;
            result  <= '0;
            found   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_STEP;
          end
        end
`ifdef SAR_CMP_PIPE_EN
        // Comparator output is one register behind guess; flags are not trusted here.
        S_SETTLE: state <= S_PROBE;
`endif
        S_PROBE: begin
          unique case (flags)
            3'b001: begin
              result <= guess;
              found  <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end
            3'b010: begin
              if (last_bit) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                guess   <= guess_up;
                bit_idx <= bit_idx - IW'(1);
                state   <= S_STEP;
              end
            end
            3'b100: begin
              guess <= guess_down;
              if (last_bit) begin
                result <= guess_down;
                found  <= 1'b1;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                bit_idx <= bit_idx - IW'(1);
                state   <= S_STEP;
              end
            end
            default: begin
              err   <= 1'b1;
              found <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          endcase
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: behavioural comparator (optionally registered) plus flag injection.
module tb_sar_search_ctrl;
  localparam int N = 5;
`ifdef SAR_CMP_PIPE_EN
  localparam int CPP = 2;
`else
  localparam int CPP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_lesser, cmp_greater, cmp_equal;
  logic [N-1:0] guess, result;
  logic         busy, done, found, err;

  int           target = 0;
  logic         inj_en = 1'b0;
  logic [2:0]   inj_val = 3'b000;
  logic [2:0]   model_flags, cmp_flags;

  int           checks = 0;
  int           errors = 0;
  int           busy_cycles;
  logic [N-1:0] seq[$];

  sar_search_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_lesser(cmp_lesser), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
    .guess(guess), .busy(busy), .done(done), .found(found), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  // {lesser, greater, equal}; target may exceed 2^N-1 to provoke an impossible "greater".
  always_comb begin
    model_flags = 3'b001;
    if (target < int'(guess))      model_flags = 3'b100;
    else if (target > int'(guess)) model_flags = 3'b010;
  end

`ifdef SAR_CMP_PIPE_EN
  logic [2:0] model_q = 3'b000;
  always_ff @(posedge clk) model_q <= model_flags;
  assign cmp_flags = inj_en ? inj_val : model_q;
`else
  assign cmp_flags = inj_en ? inj_val : model_flags;
`endif
  assign {cmp_lesser, cmp_greater, cmp_equal} = cmp_flags;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int tgt);
    target = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Runs until done (bounded); optionally pulses start at a given busy cycle.
  task automatic wait_done(input int mid_start_at);
    busy_cycles = 0;
    seq.delete();
    for (int c = 0; c < 4*N+4 && !done; c++) begin
      if (busy) begin
        seq.push_back(guess);
        busy_cycles++;
      end
      start = (mid_start_at != 0 && busy_cycles == mid_start_at);
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({guess, result, busy, done, found, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: guess=%0d result=%0d busy=%b done=%b found=%b err=%b required all 0",
               guess, result, busy, done, found, err);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_equal_first();
    launch(16);
    wait_done(0);
    checks++;
    if (result !== 5'd16 || found !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL eq_first_result: result=%0d found=%b err=%b required 16 1 0", result, found, err);
    end
    checks++;
    if (busy_cycles != CPP) begin
      errors++;
      $display("FAIL eq_first_latency: cycles=%0d required %0d", busy_cycles, CPP);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== 1'b1 || result !== 5'd16 || guess !== 5'd16) begin
      errors++;
      $display("FAIL eq_first_hold: done=%b busy=%b found=%b result=%0d guess=%0d required 0 0 1 16 16",
               done, busy, found, result, guess);
    end
  endtask

  task automatic test_all_lesser();
    logic [N-1:0] exp_seq [5] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};
    launch(0);
    wait_done(0);
    checks++;
    if (result !== 5'd0 || found !== 1'b1 || err !== 1'b0 || busy_cycles != 5*CPP) begin
      errors++;
      $display("FAIL zero_result: result=%0d found=%b err=%b cycles=%0d required 0 1 0 %0d",
               result, found, err, busy_cycles, 5*CPP);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seq.size() <= i*CPP || seq[i*CPP] !== exp_seq[i]) begin
        errors++;
        $display("FAIL zero_seq[%0d]: guess=%0d required %0d", i,
                 (seq.size() > i*CPP) ? seq[i*CPP] : 5'd0, exp_seq[i]);
      end
    end
    tick();
  endtask

  task automatic test_target13();
    logic [N-1:0] exp_seq [5] = '{5'd16, 5'd8, 5'd12, 5'd14, 5'd13};
    launch(13);
    checks++;
    if (err !== 1'b0 || found !== 1'b0 || result !== 5'd0) begin
      errors++;
      $display("FAIL t13_clear_on_start: err=%b found=%b result=%0d required 0 0 0", err, found, result);
    end
    wait_done(0);
    checks++;
    if (result !== 5'd13 || found !== 1'b1 || busy_cycles != 5*CPP || guess !== 5'd13) begin
      errors++;
      $display("FAIL t13_result: result=%0d found=%b cycles=%0d guess=%0d required 13 1 %0d 13",
               result, found, busy_cycles, guess, 5*CPP);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seq.size() <= i*CPP || seq[i*CPP] !== exp_seq[i]) begin
        errors++;
        $display("FAIL t13_seq[%0d]: guess=%0d required %0d", i,
                 (seq.size() > i*CPP) ? seq[i*CPP] : 5'd0, exp_seq[i]);
      end
    end
    tick();
  endtask

  task automatic test_target31();
    logic [N-1:0] exp_seq [5] = '{5'd16, 5'd24, 5'd28, 5'd30, 5'd31};
    launch(31);
    wait_done(0);
    checks++;
    if (result !== 5'd31 || found !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL t31_result: result=%0d found=%b err=%b required 31 1 0", result, found, err);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seq.size() <= i*CPP || seq[i*CPP] !== exp_seq[i]) begin
        errors++;
        $display("FAIL t31_seq[%0d]: guess=%0d required %0d", i,
                 (seq.size() > i*CPP) ? seq[i*CPP] : 5'd0, exp_seq[i]);
      end
    end
    tick();
    // Target beyond range: comparator says greater even at 31, bit 0.
    launch(32);
    wait_done(0);
    checks++;
    if (err !== 1'b1 || found !== 1'b0 || result !== 5'd0 || busy_cycles != 5*CPP) begin
      errors++;
      $display("FAIL greater_bit0: err=%b found=%b result=%0d cycles=%0d required 1 0 0 %0d",
               err, found, result, busy_cycles, 5*CPP);
    end
    tick();
  endtask

  task automatic test_bad_flags();
    logic [2:0] bad [2] = '{3'b011, 3'b000};
    for (int b = 0; b < 2; b++) begin
      launch(13);
      repeat (2*CPP) tick();
      inj_en  = 1'b1;
      inj_val = bad[b];
      wait_done(0);
      inj_en  = 1'b0;
      checks++;
      if (err !== 1'b1 || found !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_flags_%0d: err=%b found=%b busy=%b required 1 0 0", b, err, found, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL bad_flags_idle_%0d: done=%b busy=%b err=%b required 0 0 1", b, done, busy, err);
      end
    end
  endtask

  task automatic test_start_while_busy();
    launch(13);
    wait_done(2);
    checks++;
    if (result !== 5'd13 || found !== 1'b1 || busy_cycles != 5*CPP) begin
      errors++;
      $display("FAIL busy_start: result=%0d found=%b cycles=%0d required 13 1 %0d",
               result, found, busy_cycles, 5*CPP);
    end
    // start raised during DONE must not launch
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: busy=%b done=%b required 0 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || result !== 5'd13) begin
      errors++;
      $display("FAIL done_start_no_launch: busy=%b result=%0d required 0 13", busy, result);
    end
  endtask

  task automatic test_start_held();
    int c;
    target = 16;
    start  = 1'b1;
    tick();
    c = 0;
    while (!done && c < 4*N+4) begin
      tick();
      c++;
    end
    checks++;
    if (done !== 1'b1 || result !== 5'd16) begin
      errors++;
      $display("FAIL held_first: done=%b result=%0d required 1 16", done, result);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_idle: busy=%b done=%b required 0 0", busy, done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || guess !== 5'd16 || found !== 1'b0) begin
      errors++;
      $display("FAIL held_relaunch: busy=%b guess=%0d found=%b required 1 16 0", busy, guess, found);
    end
    wait_done(0);
    tick();
  endtask

  task automatic test_reset_mid();
    launch(13);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({guess, result, busy, done, found, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: guess=%0d result=%0d busy=%b done=%b found=%b err=%b required all 0",
               guess, result, busy, done, found, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || guess !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b done=%b guess=%0d required 0 0 0", busy, done, guess);
    end
  endtask

  initial begin
    test_reset();
    test_equal_first();
    test_all_lesser();
    test_target13();
    test_target31();
    test_bad_flags();
    test_start_while_busy();
    test_start_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
